// File: rtl/sap_div8.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with a
// nibble-sliced carry-lookahead subtractor for the trial step.
module sap_div8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               no_borrow;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   acc_next;

    // 4-bit carry-lookahead adder slice, returns {carry_out, sum}
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Trial subtract: shifted + ~{0,divisor} + 1; the top bit of ~{0,divisor} is 1,
    // so the final carry is shifted[WIDTH] | nibble-chain carry.
    always_comb begin
        logic [4:0] nib;
        logic       carry;
        nib     = '0;
        carry   = 1'b1;
        diff    = '0;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        for (int i = 0; i < int'(NIB); i++) begin
            nib              = cla4(shifted[4*i +: 4], ~dvs_q[4*i +: 4], carry);
            diff[4*i +: 4]   = nib[3:0];
            carry            = nib[4];
        end
        no_borrow = shifted[WIDTH] | carry;
        rem_next  = no_borrow ? diff : shifted[WIDTH-1:0];
        acc_next  = {acc_q[WIDTH-2:0], no_borrow};
    end

    // Next-state and register-input logic
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = '0;
                    acc_d = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                busy_d = 1'b1;
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                rem_d  = rem_next;
                acc_d  = acc_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = acc_next;
                    remainder_d = rem_next;
                    dbz_d       = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
